mem_arbiter: RTL and testbench

- Shares one unified single-port memory between the core's instruction-fetch port (imem_*) and data port (dmem_*).
- Sits between the minuteCore top level and the system memory model or SoC bus.
- Grants one transaction at a time, holds address/data stable in registers for the whole transaction, and returns ready/data to the granted side only.
- Fixed priority by default: data side beats fetch side.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter: arbiter states, grant sides and store-size codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IMEM = 2'd1,
    ARB_DMEM = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IMEM = 1'b0,
    GRANT_DMEM = 1'b1
  } grant_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port memory; one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin on contention (default: data side wins).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_rd_addr,
  input  logic              imem_rd_enable,
  output logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_rd_ready,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_r_enable,
  input  logic              dmem_w_enable,
  input  logic [1:0]        dmem_w_size,
  input  logic [DATA_W-1:0] dmem_w_data,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wsize,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_imem,
  output logic              grant_dmem
);

  arb_state_t state, state_nxt;
  logic       d_req, i_req, pick_dmem;

  assign d_req = dmem_r_enable | dmem_w_enable;
  assign i_req = imem_rd_enable;

`ifdef MEM_ARB_RR_EN
  grant_t last_grant;
  // On contention the side served last time yields; a lone requester always wins.
  assign pick_dmem = d_req & (~i_req | (last_grant == GRANT_IMEM));
`else
  assign pick_dmem = d_req;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (pick_dmem)  state_nxt = ARB_DMEM;
        else if (i_req) state_nxt = ARB_IMEM;
      end
      ARB_IMEM, ARB_DMEM: begin
        if (mem_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wsize <= SIZE_B;
      mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= GRANT_IMEM;
`endif
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && state_nxt == ARB_DMEM) begin
        mem_req   <= 1'b1;
        mem_we    <= dmem_w_enable;
        mem_addr  <= dmem_addr;
        mem_wsize <= dmem_w_size;
        mem_wdata <= dmem_w_data;
`ifdef MEM_ARB_RR_EN
        last_grant <= GRANT_DMEM;
`endif
      end else if (state == ARB_IDLE && state_nxt == ARB_IMEM) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= imem_rd_addr;
        mem_wsize <= SIZE_B;
`ifdef MEM_ARB_RR_EN
        last_grant <= GRANT_IMEM;
`endif
      end else if (state != ARB_IDLE && mem_ready) begin
        mem_req <= 1'b0;
      end
    end
  end

  assign grant_imem = (state == ARB_IMEM);
  assign grant_dmem = (state == ARB_DMEM);

  // Completion and read data reach only the granted side; idle or reset hides stray responses.
  assign imem_rd_ready = grant_imem & mem_ready;
  assign dmem_ready    = grant_dmem & mem_ready;
  assign imem_rd_data  = grant_imem ? mem_rdata : '0;
  assign dmem_r_data   = grant_dmem ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard-driven memory responder.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rd_addr, imem_rd_data;
  logic        imem_rd_enable, imem_rd_ready;
  logic [31:0] dmem_addr, dmem_w_data, dmem_r_data;
  logic        dmem_r_enable, dmem_w_enable, dmem_ready;
  logic [1:0]  dmem_w_size, mem_wsize;
  logic        mem_req, mem_we, mem_ready, grant_imem, grant_dmem;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_rd_addr(imem_rd_addr), .imem_rd_enable(imem_rd_enable),
    .imem_rd_data(imem_rd_data), .imem_rd_ready(imem_rd_ready),
    .dmem_addr(dmem_addr), .dmem_r_enable(dmem_r_enable), .dmem_w_enable(dmem_w_enable),
    .dmem_w_size(dmem_w_size), .dmem_w_data(dmem_w_data),
    .dmem_r_data(dmem_r_data), .dmem_ready(dmem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wsize(mem_wsize),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_imem(grant_imem), .grant_dmem(grant_dmem)
  );

  typedef struct {
    logic        dside;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  wsize;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        scramble;
    logic        flush;
    logic        drop;
  } txn_t;

  typedef struct {
    logic        i_en;
    logic [31:0] i_addr;
    logic        r_en;
    logic        w_en;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    int          delay;
    logic [31:0] rdata;
    logic        scramble;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [1:0]  exp_wsize;
    logic [31:0] exp_wdata;
    logic        exp_dside;
  } vec_t;

  txn_t sb[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic drop_side(input logic dside);
    if (dside) begin
      dmem_r_enable = 1'b0;
      dmem_w_enable = 1'b0;
    end else begin
      imem_rd_enable = 1'b0;
    end
  endtask

  // Memory responder: waits for a request, checks it against the oldest expectation, answers it.
  task automatic serve(input string tag);
    txn_t t;
    int   n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!mem_req && n < 20);
    check({tag, " issue_latency"}, n, 1);
    check_bit({tag, " sb_pending"}, sb.size() != 0, 1'b1);
    if (!mem_req || sb.size() == 0) return;
    t = sb.pop_front();
    check_bit({tag, " mem_we"}, mem_we, t.we);
    check({tag, " mem_addr"}, mem_addr, t.addr);
    check({tag, " mem_wsize"}, {30'b0, mem_wsize}, {30'b0, t.wsize});
    if (t.dside) check({tag, " mem_wdata"}, mem_wdata, t.wdata);
    check_bit({tag, " grant_dmem"}, grant_dmem, t.dside);
    check_bit({tag, " grant_imem"}, grant_imem, !t.dside);
    if (t.flush) drop_side(t.dside);
    for (int d = 0; d < t.delay; d++) begin
      if (t.scramble) begin
        dmem_addr    = $urandom;
        dmem_w_data  = $urandom;
        imem_rd_addr = $urandom;
      end
      @(negedge clk); #1;
      check_bit({tag, " stall_req"}, mem_req, 1'b1);
      check({tag, " stall_addr"}, mem_addr, t.addr);
      if (t.dside) check({tag, " stall_wdata"}, mem_wdata, t.wdata);
      check_bit({tag, " stall_ready"}, imem_rd_ready | dmem_ready, 1'b0);
    end
    mem_rdata = t.rdata;
    mem_ready = 1'b1;
    #1;
    check_bit({tag, " imem_rd_ready"}, imem_rd_ready, !t.dside);
    check_bit({tag, " dmem_ready"}, dmem_ready, t.dside);
    check({tag, " imem_rd_data"}, imem_rd_data, t.dside ? 32'h0 : t.rdata);
    check({tag, " dmem_r_data"}, dmem_r_data, t.dside ? t.rdata : 32'h0);
    if (t.drop) drop_side(t.dside);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    check_bit({tag, " idle_req"}, mem_req, 1'b0);
    check_bit({tag, " idle_grant"}, grant_imem | grant_dmem, 1'b0);
    check_bit({tag, " idle_ready"}, imem_rd_ready | dmem_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t st, ft;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 2'd2, 32'h0, 1, 32'h13, 1'b0,
                1'b0, 32'h100, 2'd0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 2'd2, 32'h0, 0, 32'hCAFEF00D, 1'b0,
                1'b0, 32'h3000, 2'd2, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h2001, 2'd0, 32'hA5, 2, 32'h0, 1'b0,
                1'b1, 32'h2001, 2'd0, 32'hA5, 1'b1};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h2002, 2'd1, 32'h1234, 0, 32'h0, 1'b0,
                1'b1, 32'h2002, 2'd1, 32'h1234, 1'b1};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2004, 2'd2, 32'h55AA55AA, 1, 32'h11112222, 1'b0,
                1'b1, 32'h2004, 2'd2, 32'h55AA55AA, 1'b1};
    vecs[5] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h9999, 2'd2, 32'h77, 0, 32'h00400093, 1'b0,
                1'b0, 32'h104, 2'd0, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 2'd1, 32'hBEEF, 5, 32'h87654321, 1'b1,
                1'b0, 32'h4000, 2'd1, 32'hBEEF, 1'b1};

    // Reset state, with a live-looking memory response that must stay hidden.
    reset = 1'b1;
    imem_rd_enable = 1'b0; imem_rd_addr = 32'h0;
    dmem_r_enable = 1'b0; dmem_w_enable = 1'b0;
    dmem_addr = 32'h0; dmem_w_size = 2'd0; dmem_w_data = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    #1;
    check_bit("rst mem_req", mem_req, 1'b0);
    check_bit("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wsize", {30'b0, mem_wsize}, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check_bit("rst readies", imem_rd_ready | dmem_ready, 1'b0);
    check("rst imem_rd_data", imem_rd_data, 32'h0);
    check("rst dmem_r_data", dmem_r_data, 32'h0);
    check_bit("rst grants", grant_imem | grant_dmem, 1'b0);
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); #1;

    // Contention: store and fetch raised together; the store stays requested once more.
    imem_rd_enable = 1'b1; imem_rd_addr = 32'h200;
    dmem_w_enable = 1'b1; dmem_addr = 32'h2000; dmem_w_data = 32'hDEADBEEF; dmem_w_size = 2'd2;
    st = '{dside:1'b1, we:1'b1, addr:32'h2000, wsize:2'd2, wdata:32'hDEADBEEF,
           rdata:32'h0, delay:1, scramble:1'b0, flush:1'b0, drop:1'b0};
    ft = '{dside:1'b0, we:1'b0, addr:32'h200, wsize:2'd0, wdata:32'h0,
           rdata:32'h13, delay:0, scramble:1'b0, flush:1'b0, drop:1'b1};
    sb.push_back(st);
    st.drop = 1'b1;
`ifdef MEM_ARB_RR_EN
    sb.push_back(ft);
    sb.push_back(st);
`else
    sb.push_back(st);
    sb.push_back(ft);
`endif
    for (int k = 0; k < 3; k++) serve($sformatf("contend%0d", k));
    @(negedge clk); #1;
    check_bit("contend quiet", mem_req, 1'b0);

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      txn_t t;
      imem_rd_enable = vecs[i].i_en;
      imem_rd_addr   = vecs[i].i_addr;
      dmem_r_enable  = vecs[i].r_en;
      dmem_w_enable  = vecs[i].w_en;
      dmem_addr      = vecs[i].d_addr;
      dmem_w_size    = vecs[i].d_size;
      dmem_w_data    = vecs[i].d_wdata;
      t = '{dside:vecs[i].exp_dside, we:vecs[i].exp_we, addr:vecs[i].exp_addr,
            wsize:vecs[i].exp_wsize, wdata:vecs[i].exp_wdata, rdata:vecs[i].rdata,
            delay:vecs[i].delay, scramble:vecs[i].scramble, flush:1'b0, drop:1'b1};
      sb.push_back(t);
      serve($sformatf("vec%0d", i));
      @(negedge clk); #1;
      check_bit($sformatf("vec%0d quiet", i), mem_req, 1'b0);
    end

    // Flush: fetch dropped right after grant still completes, with no second request.
    imem_rd_enable = 1'b1; imem_rd_addr = 32'h104;
    ft = '{dside:1'b0, we:1'b0, addr:32'h104, wsize:2'd0, wdata:32'h0,
           rdata:32'h0000A0B0, delay:2, scramble:1'b0, flush:1'b1, drop:1'b1};
    sb.push_back(ft);
    serve("flush");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check_bit("flush quiet", mem_req, 1'b0);
    end

    // Reset during a data transaction, then a stray memory response.
    dmem_r_enable = 1'b1; dmem_addr = 32'h5000;
    @(negedge clk); #1;
    check_bit("rstmid req", mem_req, 1'b1);
    check_bit("rstmid grant", grant_dmem, 1'b1);
    reset = 1'b1;
    dmem_r_enable = 1'b0;
    @(negedge clk); #1;
    check_bit("rstmid req_drop", mem_req, 1'b0);
    check_bit("rstmid grants", grant_imem | grant_dmem, 1'b0);
    check("rstmid addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    check_bit("stray readies", imem_rd_ready | dmem_ready, 1'b0);
    check("stray dmem_r_data", dmem_r_data, 32'h0);
    check("stray imem_rd_data", imem_rd_data, 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_bit("stray quiet", mem_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
